// File: rtl/sar_adc_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sar_adc_scheduler
// Purpose  : Round-robin scheduler sharing one SAR ADC between NCH requesters;
//            drives mux/sample switch, runs the binary search, returns tagged
//            results over valid/ready. Optional macro SAR_SCHED_SCAN_EN adds
//            a scan_en input that forces cyclic conversion of all channels.
// Revision : 1.0 - initial release
// ============================================================================
module sar_adc_scheduler #(
    parameter int NCH        = 4,
    parameter int NBITS      = 3,
    parameter int SAMPLE_CYC = 2,
    parameter int SETTLE_CYC = 1,
    parameter int CHW        = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             reset_n,
`ifdef SAR_SCHED_SCAN_EN
    input  logic             scan_en,
`endif
    input  logic [NCH-1:0]   req,
    output logic [NCH-1:0]   ack,
    output logic [CHW-1:0]   mux_sel,
    output logic             sample_en,
    output logic [NBITS-1:0] dac_code,
    input  logic             cmp,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [NBITS-1:0] result_data,
    output logic [CHW-1:0]   result_ch
);

    localparam int c_CMAX = (SAMPLE_CYC > SETTLE_CYC) ? SAMPLE_CYC : SETTLE_CYC;
    localparam int c_CNTW = (c_CMAX > 1) ? $clog2(c_CMAX) : 1;
    localparam int c_BW   = (NBITS > 1) ? $clog2(NBITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SAMPLE = 2'd1,
        S_TRIAL  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             r_state,  w_state_nxt;
    logic [CHW-1:0]     r_ptr,    w_ptr_nxt;
    logic [c_CNTW-1:0]  r_cnt,    w_cnt_nxt;
    logic [c_BW-1:0]    r_bit,    w_bit_nxt;
    logic [NCH-1:0]     r_ack,    w_ack_nxt;
    logic [CHW-1:0]     r_mux,    w_mux_nxt;
    logic               r_sample, w_sample_nxt;
    logic [NBITS-1:0]   r_dac,    w_dac_nxt;
    logic               r_busy,   w_busy_nxt;
    logic               r_valid,  w_valid_nxt;
    logic [NBITS-1:0]   r_data,   w_data_nxt;
    logic [CHW-1:0]     r_rch,    w_rch_nxt;

    logic [NCH-1:0]     w_req;
    logic               w_gnt_vld;
    logic [CHW-1:0]     w_gnt_ch;
    logic               w_grant;
    logic [NBITS-1:0]   w_code;

`ifdef SAR_SCHED_SCAN_EN
    assign w_req = scan_en ? {NCH{1'b1}} : req;
`else
    assign w_req = req;
`endif

    function automatic logic [CHW-1:0] f_wrap(input int v);
        return CHW'(v % NCH);
    endfunction

    // Descending offset scan: the last hit is the nearest channel after r_ptr.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_ch  = '0;
        for (int i = NCH; i >= 1; i--) begin
            if (w_req[f_wrap(int'(r_ptr) + i)]) begin
                w_gnt_vld = 1'b1;
                w_gnt_ch  = f_wrap(int'(r_ptr) + i);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_ptr_nxt    = r_ptr;
        w_cnt_nxt    = r_cnt;
        w_bit_nxt    = r_bit;
        w_ack_nxt    = '0;
        w_mux_nxt    = r_mux;
        w_sample_nxt = r_sample;
        w_dac_nxt    = r_dac;
        w_valid_nxt  = r_valid;
        w_data_nxt   = r_data;
        w_rch_nxt    = r_rch;
        w_grant      = 1'b0;
        w_code       = r_dac;

        case (r_state)
            S_IDLE: begin
                w_grant = w_gnt_vld;
            end
            S_SAMPLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt          = S_TRIAL;
                    w_sample_nxt         = 1'b0;
                    w_bit_nxt            = c_BW'(NBITS - 1);
                    w_dac_nxt            = '0;
                    w_dac_nxt[NBITS-1]   = 1'b1;
                    w_cnt_nxt            = c_CNTW'(SETTLE_CYC - 1);
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_TRIAL: begin
                if (r_cnt == '0) begin
                    if (!cmp) begin
                        w_code[r_bit] = 1'b0;
                    end
                    if (r_bit != '0) begin
                        w_code[r_bit - 1'b1] = 1'b1;
                        w_bit_nxt            = r_bit - 1'b1;
                        w_cnt_nxt            = c_CNTW'(SETTLE_CYC - 1);
                    end else begin
                        w_state_nxt = S_DONE;
                        w_valid_nxt = 1'b1;
                        w_data_nxt  = w_code;
                        w_rch_nxt   = r_mux;
                    end
                    w_dac_nxt = w_code;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_DONE: begin
                if (r_valid && result_ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = S_IDLE;
                    w_grant     = w_gnt_vld;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_grant) begin
            w_state_nxt          = S_SAMPLE;
            w_ptr_nxt            = w_gnt_ch;
            w_ack_nxt[w_gnt_ch]  = 1'b1;
            w_mux_nxt            = w_gnt_ch;
            w_sample_nxt         = 1'b1;
            w_cnt_nxt            = c_CNTW'(SAMPLE_CYC - 1);
        end

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= CHW'(NCH - 1);
            r_cnt    <= '0;
            r_bit    <= '0;
            r_ack    <= '0;
            r_mux    <= '0;
            r_sample <= 1'b0;
            r_dac    <= '0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_rch    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ptr    <= w_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bit    <= w_bit_nxt;
            r_ack    <= w_ack_nxt;
            r_mux    <= w_mux_nxt;
            r_sample <= w_sample_nxt;
            r_dac    <= w_dac_nxt;
            r_busy   <= w_busy_nxt;
            r_valid  <= w_valid_nxt;
            r_data   <= w_data_nxt;
            r_rch    <= w_rch_nxt;
        end
    end

    assign ack          = r_ack;
    assign mux_sel      = r_mux;
    assign sample_en    = r_sample;
    assign dac_code     = r_dac;
    assign busy         = r_busy;
    assign result_valid = r_valid;
    assign result_data  = r_data;
    assign result_ch    = r_rch;

endmodule
`default_nettype wire

// File: tb/tb_sar_adc_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sar_adc_scheduler
// Purpose  : Randomized scoreboard bench for sar_adc_scheduler with an
//            ideal-comparator channel model and a round-robin grant model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sar_adc_scheduler;

    localparam int NCH        = 4;
    localparam int NBITS      = 3;
    localparam int SAMPLE_CYC = 2;
    localparam int SETTLE_CYC = 1;
    localparam int CHW        = 2;
    localparam int c_LAT      = SAMPLE_CYC + NBITS * SETTLE_CYC;
    localparam int c_PERIOD   = c_LAT + 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             scan_en = 1'b0;
    logic [NCH-1:0]   req = '0;
    logic [NCH-1:0]   ack;
    logic [CHW-1:0]   mux_sel;
    logic             sample_en;
    logic [NBITS-1:0] dac_code;
    logic             cmp;
    logic             busy;
    logic             result_valid;
    logic             result_ready = 1'b0;
    logic [NBITS-1:0] result_data;
    logic [CHW-1:0]   result_ch;

    sar_adc_scheduler #(
        .NCH(NCH), .NBITS(NBITS), .SAMPLE_CYC(SAMPLE_CYC), .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
`ifdef SAR_SCHED_SCAN_EN
        .scan_en(scan_en),
`endif
        .req(req),
        .ack(ack),
        .mux_sel(mux_sel),
        .sample_en(sample_en),
        .dac_code(dac_code),
        .cmp(cmp),
        .busy(busy),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .result_data(result_data),
        .result_ch(result_ch)
    );

    always #5 clk = ~clk;

    // Analog side: each channel carries an integer level; ideal comparator.
    logic [NBITS-1:0] v [NCH];
    int cmp_mode = 0;   // 0 = ideal comparator, 1 = stuck high, 2 = stuck low
    assign cmp = (cmp_mode == 1) ? 1'b1 :
                 (cmp_mode == 2) ? 1'b0 : (v[mux_sel] >= dac_code);

    typedef struct packed {
        logic [CHW-1:0]   ch;
        logic [NBITS-1:0] data;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int req_pct = 0;
    int ready_mode = 0; // 0 = always ready, 1 = random with stalls, 2 = never
    int stall = 0;
    bit full_rate = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NCH-1:0] r, input int last);
        for (int i = 1; i <= NCH; i++) begin
            if (((r >> ((last + i) % NCH)) & 1) != 0) return (last + i) % NCH;
        end
        return -1;
    endfunction

    // ---------------------------------------------------------------- monitor
    logic [NCH-1:0]   p_req = '0;
    logic             p_busy = 0, p_valid = 0, p_ready = 0, p_scan = 0;
    logic [NBITS-1:0] p_data = '0;
    logic [CHW-1:0]   p_ch = '0;
    int m_last = NCH - 1, m_ack_cyc = 0, m_last_ack = -1, m_sen = 0;

    initial begin : monitor
        int   g;
        logic exp_ack;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset_n) begin
                sb.delete();
                m_last = NCH - 1;
                m_last_ack = -1;
                p_req = req; p_busy = 0; p_valid = 0; p_ready = 0; p_scan = scan_en;
                continue;
            end
            if (!full_rate) m_last_ack = -1;

            exp_ack = (!p_busy || (p_valid && p_ready)) && ((p_req != '0) || p_scan);
            chk("ack_when", 32'(ack != '0), 32'(exp_ack));
            if (ack != '0) begin
                g = rr_pick(p_scan ? {NCH{1'b1}} : p_req, m_last);
                chk("ack_ch", 32'(ack), 32'(1) << g);
                chk("mux_sel", 32'(mux_sel), 32'(g));
                if (full_rate && m_last_ack >= 0)
                    chk("spacing", 32'(cyc - m_last_ack), c_PERIOD);
                m_last_ack = cyc;
                m_ack_cyc  = cyc;
                m_sen      = 0;
                if (g >= 0) m_last = g;
                e.ch   = CHW'(g);
                e.data = (cmp_mode == 1) ? {NBITS{1'b1}} :
                         (cmp_mode == 2) ? '0 : v[g];
                sb.push_back(e);
            end
            if (sample_en) m_sen++;

            if (result_valid && !p_valid) begin
                chk("latency", 32'(cyc - m_ack_cyc), c_LAT);
                chk("sample_len", 32'(m_sen), SAMPLE_CYC);
            end
            if (p_valid && !p_ready) begin
                chk("hold_valid", 32'(result_valid), 1);
                chk("hold_data", 32'(result_data), 32'(p_data));
                chk("hold_ch", 32'(result_ch), 32'(p_ch));
                chk("hold_busy", 32'(busy), 1);
            end
            if (result_valid && result_ready) begin
                if (sb.size() == 0) begin
                    chk("result_unexpected", 32'(result_valid), 0);
                end else begin
                    e = sb.pop_front();
                    chk("result_ch", 32'(result_ch), 32'(e.ch));
                    chk("result_data", 32'(result_data), 32'(e.data));
                end
            end
            p_req = req; p_busy = busy; p_valid = result_valid; p_ready = result_ready;
            p_data = result_data; p_ch = result_ch; p_scan = scan_en;
        end
    end

    // ---------------------------------------------------------------- driver
    task automatic step();
        @(posedge clk);
        #2;
        for (int c = 0; c < NCH; c++) begin
            if (ack[c]) begin
                req[c] = 1'b0;
            end else if (!req[c] && ($urandom_range(99) < req_pct) &&
                         !(busy && (int'(mux_sel) == c))) begin
                v[c]   = NBITS'($urandom);
                req[c] = 1'b1;
            end
        end
        if (ready_mode == 0) begin
            result_ready = 1'b1;
        end else if (ready_mode == 2) begin
            result_ready = 1'b0;
        end else if (stall > 0) begin
            result_ready = 1'b0;
            stall--;
        end else if ($urandom_range(19) == 0) begin
            result_ready = 1'b0;
            stall = 10;
        end else begin
            result_ready = ($urandom_range(3) != 0);
        end
    endtask

    task automatic drain();
        int n;
        req_pct = 0;
        n = 0;
        while ((req != '0 || busy) && n < 400) begin
            step();
            n++;
        end
        step();
        chk("drain_busy", 32'(busy), 0);
        chk("drain_sb", 32'(sb.size()), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"}, 32'(ack), 0);
        chk({tag, "_mux_sel"}, 32'(mux_sel), 0);
        chk({tag, "_sample_en"}, 32'(sample_en), 0);
        chk({tag, "_dac_code"}, 32'(dac_code), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_result_valid"}, 32'(result_valid), 0);
        chk({tag, "_result_data"}, 32'(result_data), 0);
        chk({tag, "_result_ch"}, 32'(result_ch), 0);
    endtask

    initial begin : stimulus
        int n;
        for (int c = 0; c < NCH; c++) v[c] = NBITS'($urandom);
        repeat (3) @(posedge clk);
        #2;
        chk_reset_outputs("rst");
        #1 reset_n = 1'b1;

        // single request on channel 2, level 5 -> code 101
        v[2] = 3'd5;
        req  = 4'b0100;
        drain();

        // continuous requests, always ready: back-to-back grants
        full_rate = 1'b1;
        req_pct   = 100;
        repeat (60) step();
        full_rate = 1'b0;
        drain();

        // comparator stuck high / stuck low
        cmp_mode = 1; req_pct = 30; repeat (40) step(); drain();
        cmp_mode = 2; req_pct = 30; repeat (40) step(); drain();
        cmp_mode = 0;

        // random traffic with random back-pressure
        ready_mode = 1; req_pct = 15;
        repeat (800) step();
        drain();
        ready_mode = 0;

        // long stall in DONE while another channel waits
        ready_mode = 2;
        req = 4'b1000;
        n = 0;
        while (!result_valid && n < 30) begin step(); n++; end
        chk("stall_reach_done", 32'(result_valid), 1);
        v[0] = NBITS'($urandom);
        req[0] = 1'b1;
        repeat (10) step();
        ready_mode = 0;
        drain();

        // asynchronous reset in the middle of a trial
        req = 4'b0001;
        n = 0;
        while (!ack[0] && n < 20) begin step(); n++; end
        chk("pre_reset_ack", 32'(ack), 32'b0001);
        repeat (3) step();
        #1 reset_n = 1'b0;
        #1 chk_reset_outputs("async_rst");
        req = '0;
        repeat (2) step();
        chk("in_reset_valid", 32'(result_valid), 0);
        #1 reset_n = 1'b1;
        step();
        req = 4'b0011;
        drain();

`ifdef SAR_SCHED_SCAN_EN
        scan_en = 1'b1;
        repeat (30) step();
        scan_en = 1'b0;
        drain();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/sar_adc_scheduler.md
# sar_adc_scheduler

Controller that shares one SAR ADC (3-bit by default) between NCH requesters. It arbitrates round-robin between the requesters and drives the analog input mux and the sample/hold switch. It runs a bit-serial binary successive-approximation search on the DAC code using the comparator output, and returns the result, tagged with its channel, over a valid/ready handshake. It sits between the digital requesters and the analog mux/DAC/comparator front end.

## Interface
Parameters:
- NCH, 4: number of requesting channels (≥2); CHW = $clog2(NCH)
- NBITS, 3: conversion resolution (≥1)
- SAMPLE_CYC, 2: cycles the sample switch stays closed (≥1)
- SETTLE_CYC, 1: DAC/comparator settle cycles per trial bit (≥1)

Ports:
- clk  in  1  single clock, all state on posedge
- reset_n  in  1  asynchronous, active-low reset
- req  in  NCH  level request per channel; held by requester until its ack
- ack  out  NCH  one-cycle one-hot pulse: request accepted, conversion started
- mux_sel  out  CHW  analog mux channel select
- sample_en  out  1  sample/hold switch closed while high
- dac_code  out  NBITS  trial code to DAC
- cmp  in  1  comparator: 1 = input ≥ DAC voltage for current dac_code
- busy  out  1  high in every state except IDLE
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- result_data  out  NBITS  converted code
- result_ch  out  CHW  channel of result_data

## Operation
- Outputs are registered.
- Reset values: ack=0, mux_sel=0, sample_en=0, dac_code=0, busy=0, result_valid=0, result_data=0, result_ch=0, state=IDLE, rr pointer=NCH-1 (channel 0 has priority first).
- States: IDLE, SAMPLE, TRIAL, DONE.
- Arbitration: round-robin. Search starts at (last granted + 1) mod NCH. The granted index is latched as ch.
- IDLE: if req≠0, arbitrate, then go to SAMPLE. Set ack[ch]=1 for one cycle, mux_sel=ch, sample_en=1, counter=SAMPLE_CYC-1.
- SAMPLE: decrement the counter each cycle. At count 0, go to TRIAL with sample_en=0, bit=NBITS-1, dac_code=1<<(NBITS-1), counter=SETTLE_CYC-1.
- TRIAL: decrement the counter each cycle. At count 0, resolve the current bit:
  - If cmp=0, clear dac_code[bit].
  - If bit>0, set dac_code[bit-1], decrement bit, reload the counter.
  - If bit=0, go to DONE with result_data = resolved code, result_ch=ch, result_valid=1.
- DONE:
  - result_valid, result_data and result_ch stay stable until the result_valid&result_ready edge.
  - On that edge, clear result_valid.
  - If req≠0 on that same edge, arbitrate and go straight to SAMPLE (no IDLE bubble). Otherwise go to IDLE.
- mux_sel holds ch from grant until the next grant.
- dac_code holds the final code in DONE and IDLE.
- req changes after ack are ignored until the next arbitration point.
- Only IDLE and the DONE handshake edge are arbitration points.
- req of the channel being converted is ignored until its ack. A requester that re-asserts after ack is queued normally.
- cmp is sampled only on the resolve edge of TRIAL. It is ignored in all other states.
- result_ready is ignored outside DONE.
- reset_n low at any time aborts the conversion immediately: all outputs go to reset values and no partial result is emitted.

## Timing
- E0 is the arbitration edge. ack and sample_en are high from E0 to E0+1.
- sample_en is high for exactly SAMPLE_CYC cycles.
- The first trial code appears at E0+SAMPLE_CYC.
- result_valid rises at E0+SAMPLE_CYC+NBITS·SETTLE_CYC. With defaults this is E0+5.
- With result_ready tied high and continuous requests:
  - result_valid is high for 1 cycle per conversion.
  - Throughput is one conversion per SAMPLE_CYC+NBITS·SETTLE_CYC+1 cycles (6 with defaults).

## Configuration
- SAR_SCHED_SCAN_EN:
  - Defined: adds input scan_en (1 bit). While scan_en=1, the arbiter treats req as all-ones, so channels are converted 0,1,…,NCH-1 cyclically. ack still pulses for the granted channel.
  - Undefined: port absent; only req drives arbitration.

## Test plan
- Reset then single req[2]=1 with cmp = (dac_code ≤ 5) -> ack=0100 at E0+1, sample_en high for 2 cycles, dac_code sequence 100,110,101, result_data=101, result_ch=2, result_valid at E0+5.
- req=1111 held, result_ready=1 -> acks in order ch0,ch1,ch2,ch3,ch0, one result every 6 cycles, no IDLE bubble between conversions.
- result_ready=0 for 10 cycles in DONE -> result_valid/data/ch stable, no new ack, busy=1; ready=1 -> handshake, next grant on the same edge.
- cmp=1 always -> 111; cmp=0 always -> 000; alternating per trial starting 1 -> 101.
- reset_n low mid-TRIAL -> all outputs 0 asynchronously, no result_valid; after release with req[1] -> ack[1], rr pointer restarted from NCH-1.
- SAR_SCHED_SCAN_EN defined, scan_en=1, req=0 -> channels 0..3 converted cyclically with results tagged 0,1,2,3.
